// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit bit-serial adder that time-shares one fullAdder cell, LSB first, behind a start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the OVF output (two's-complement overflow of the completed sum).
module fullAdder (
    input  logic X1,
    input  logic X2,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = X1 ^ X2 ^ Cin;
    assign Cout = (X1 & X2) | (Cin & (X1 ^ X2));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, s_q, sum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, busy_q, done_q, cout_q;
    logic             fa_s, fa_cout, last_bit;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    fullAdder u_fa (
        .X1  (a_q[0]),
        .X2  (b_q[0]),
        .Cin (carry_q),
        .S   (fa_s),
        .Cout(fa_cout)
    );

    assign sum_d    = {fa_s, sum_q[WIDTH-1:1]};
    assign last_bit = cnt_q == CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= A;
                    b_q     <= B;
                    carry_q <= Cin;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= ADD;
                end
                ADD: begin
                    sum_q   <= sum_d;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        // carry_q is the carry into the MSB while the final bit is added
                        s_q     <= sum_d;
                        cout_q  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q   <= carry_q ^ fa_cout;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign OVF  = ovf_q;
`endif
endmodule
